relay_sequencer: RTL and testbench

- Owns the latching direction relays on the four bidirectional trigger ports.
- Takes per-channel direction requests from the management register block and queues them in a per-channel pending table.
- Energizes coils one at a time, round-robin, with a fixed pulse width and a fixed post-pulse gap, and reports each channel's direction state.
- On reset it first drives every channel to output mode; only then does it accept requests.

---
 rtl/relay_sequencer.sv | 164 ++++++++++++++++
 tb/tb_relay_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relay_sequencer.sv
// Latching direction-relay sequencer: queues per-channel direction requests and
// pulses one coil at a time, round-robin, with a fixed pulse width and gap.
module relay_sequencer #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned PULSE_CYCLES = 625000,
  parameter int unsigned GAP_CYCLES   = 125000,
  parameter bit          STARTUP_INIT = 1'b1,
  localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk_125mhz,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic [CH_W-1:0]         req_channel,
  input  logic                    req_dir,
  output logic                    req_ready,
  output logic [NUM_CHANNELS-1:0] relay_a,
  output logic [NUM_CHANNELS-1:0] relay_b,
  output logic [NUM_CHANNELS-1:0] dir_state,
  output logic [NUM_CHANNELS-1:0] dir_known,
  output logic                    busy,
  output logic                    init_done
);

  localparam int unsigned CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]              state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [CH_W-1:0]         ptr, ptr_d;
  logic [CH_W-1:0]         active_ch, active_d;
  logic [NUM_CHANNELS-1:0] pending, pending_d;
  logic [NUM_CHANNELS-1:0] target, target_d;
  logic [NUM_CHANNELS-1:0] committed, committed_d;
  logic [NUM_CHANNELS-1:0] dir_state_d, dir_known_d;
  logic [NUM_CHANNELS-1:0] relay_a_d, relay_b_d;
  logic                    busy_d, init_done_d;

  logic                    found;
  logic [CH_W-1:0]         pick, cand;
  int unsigned             idx;

  assign req_ready = init_done;

  // First pending channel at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
      cand = CH_W'(idx);
      if (!found && pending[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state: launch/pulse/gap sequencing, then request evaluation on post-launch state.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    ptr_d       = ptr;
    active_d    = active_ch;
    pending_d   = pending;
    target_d    = target;
    committed_d = committed;
    dir_state_d = dir_state;
    relay_a_d   = relay_a;
    relay_b_d   = relay_b;

    case (state)
      IDLE: begin
        relay_a_d = '0;
        relay_b_d = '0;
        if (found) begin
          pending_d[pick]   = 1'b0;
          dir_state_d[pick] = target[pick];
          committed_d[pick] = 1'b1;
          active_d          = pick;
          cnt_d             = CNT_W'(PULSE_CYCLES - 1);
          state_d           = PULSE;
          if (target[pick]) relay_b_d[pick] = 1'b1;
          else              relay_a_d[pick] = 1'b1;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          relay_a_d = '0;
          relay_b_d = '0;
          cnt_d     = CNT_W'(GAP_CYCLES - 1);
          state_d   = GAP;
          ptr_d     = (active_ch == CH_W'(NUM_CHANNELS - 1)) ? '0 : active_ch + CH_W'(1);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        relay_a_d = '0;
        relay_b_d = '0;
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      default: begin
        relay_a_d = '0;
        relay_b_d = '0;
        state_d   = IDLE;
      end
    endcase

    if (req_valid && init_done) begin
      if (pending_d[req_channel]) begin
        target_d[req_channel] = req_dir;
      end else if (!(committed_d[req_channel] && dir_state_d[req_channel] == req_dir)) begin
        pending_d[req_channel] = 1'b1;
        target_d[req_channel]  = req_dir;
      end
    end

    busy_d      = (state_d != IDLE);
    dir_known_d = committed_d & ~pending_d &
                  ~(busy_d ? (NUM_CHANNELS'(1) << active_d) : NUM_CHANNELS'(0));
    init_done_d = init_done | ((state_d == IDLE) && (pending_d == '0));
  end

  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      active_ch <= '0;
      pending   <= {NUM_CHANNELS{STARTUP_INIT}};
      target    <= {NUM_CHANNELS{STARTUP_INIT}};
      committed <= '0;
      dir_state <= '0;
      dir_known <= '0;
      relay_a   <= '0;
      relay_b   <= '0;
      busy      <= 1'b0;
      init_done <= ~STARTUP_INIT;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      ptr       <= ptr_d;
      active_ch <= active_d;
      pending   <= pending_d;
      target    <= target_d;
      committed <= committed_d;
      dir_state <= dir_state_d;
      dir_known <= dir_known_d;
      relay_a   <= relay_a_d;
      relay_b   <= relay_b_d;
      busy      <= busy_d;
      init_done <= init_done_d;
    end
  end

endmodule

// File: tb/tb_relay_sequencer.sv
// Bench for relay_sequencer: expected coil pulses are queued as requests are driven
// and matched by a coil monitor; per-scenario tasks check the direction status.
module tb_relay_sequencer;

  localparam int unsigned NCH  = 4;
  localparam int unsigned PLS  = 8;
  localparam int unsigned GAPC = 4;

  typedef struct packed {
    logic [1:0] ch;
    logic       coil_b;
  } pulse_t;

  logic           clk_125mhz = 1'b0;
  logic           rst_n      = 1'b0;
  logic           req_valid  = 1'b0;
  logic [1:0]     req_channel = 2'd0;
  logic           req_dir    = 1'b0;
  logic           req_ready;
  logic [NCH-1:0] relay_a, relay_b, dir_state, dir_known;
  logic           busy, init_done;

  int n_cmp  = 0;
  int n_fail = 0;

  pulse_t exp_q[$];

  relay_sequencer #(
    .NUM_CHANNELS(NCH), .PULSE_CYCLES(PLS), .GAP_CYCLES(GAPC), .STARTUP_INIT(1'b1)
  ) dut (
    .clk_125mhz(clk_125mhz), .rst_n(rst_n), .req_valid(req_valid),
    .req_channel(req_channel), .req_dir(req_dir), .req_ready(req_ready),
    .relay_a(relay_a), .relay_b(relay_b), .dir_state(dir_state),
    .dir_known(dir_known), .busy(busy), .init_done(init_done)
  );

  always #5 clk_125mhz = ~clk_125mhz;

  // Coil monitor: invariants every cycle, pulse length/identity against the queue, gap spacing.
  logic           in_pulse  = 1'b0;
  logic           have_prev = 1'b0;
  int             low_len   = 0;
  int             plen      = 0;
  logic [NCH-1:0] cur_a, cur_b, coils;
  pulse_t         obs, want;

  always @(negedge clk_125mhz) begin
    if (!rst_n) begin
      in_pulse  = 1'b0;
      have_prev = 1'b0;
      low_len   = 0;
    end else begin
      coils = relay_a | relay_b;
      n_cmp++;
      if ($countones(coils) > 1 || (relay_a & relay_b) != '0) begin
        n_fail++;
        $display("FAIL coil_onehot: relay_a=%b relay_b=%b, required at most one coil set", relay_a, relay_b);
      end
      if (!in_pulse) begin
        if (coils != '0) begin
          if (have_prev) begin
            n_cmp++;
            if (low_len < int'(GAPC) + 1) begin
              n_fail++;
              $display("FAIL pulse_gap: low cycles=%0d, required >= %0d", low_len, GAPC + 1);
            end
          end
          in_pulse = 1'b1;
          cur_a    = relay_a;
          cur_b    = relay_b;
          plen     = 1;
        end else begin
          low_len++;
        end
      end else if (coils != '0) begin
        n_cmp++;
        if (relay_a !== cur_a || relay_b !== cur_b) begin
          n_fail++;
          $display("FAIL coil_stable: a=%b b=%b, required a=%b b=%b", relay_a, relay_b, cur_a, cur_b);
        end
        plen++;
      end else begin
        in_pulse  = 1'b0;
        have_prev = 1'b1;
        low_len   = 1;
        obs.ch     = 2'd0;
        obs.coil_b = |cur_b;
        for (int i = 0; i < int'(NCH); i++)
          if (cur_a[i] | cur_b[i]) obs.ch = 2'(i);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: ch=%0d coil_b=%0d, required no pulse", obs.ch, obs.coil_b);
        end else begin
          want = exp_q.pop_front();
          if (obs !== want || plen != int'(PLS)) begin
            n_fail++;
            $display("FAIL pulse: ch=%0d coil_b=%0d len=%0d, required ch=%0d coil_b=%0d len=%0d",
                     obs.ch, obs.coil_b, plen, want.ch, want.coil_b, PLS);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] ch, input logic coil_b);
    pulse_t p;
    p.ch     = ch;
    p.coil_b = coil_b;
    exp_q.push_back(p);
  endtask

  task automatic send_req(input logic [1:0] ch, input logic dir);
    @(negedge clk_125mhz);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready: got %b, required 1", req_ready);
    end
    req_valid   = 1'b1;
    req_channel = ch;
    req_dir     = dir;
    @(negedge clk_125mhz);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy || in_pulse) && k < budget) begin
      @(negedge clk_125mhz);
      k++;
    end
    n_cmp++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d pulses outstanding after %0d cycles, required 0", name, exp_q.size(), k);
    end
  endtask

  task automatic check_status(input string name, input logic [NCH-1:0] st, input logic [NCH-1:0] kn);
    n_cmp++;
    if (dir_state !== st || dir_known !== kn) begin
      n_fail++;
      $display("FAIL %s_status: dir_state=%h dir_known=%h, required %h %h", name, dir_state, dir_known, st, kn);
    end
  endtask

  // Release reset and run the startup sequence; a request during init must be ignored.
  task automatic run_init(input string name);
    int cyc = 0;
    @(negedge clk_125mhz);
    rst_n = 1'b1;
    while (!init_done && cyc < 200) begin
      @(posedge clk_125mhz);
      #1;
      cyc++;
      if (cyc == 2) begin
        n_cmp++;
        if (req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_ready_early: req_ready=%b, required 0", name, req_ready);
        end
        req_valid   = 1'b1;
        req_channel = 2'd2;
        req_dir     = 1'b0;
      end else if (cyc == 3) begin
        req_valid = 1'b0;
      end
    end
    n_cmp++;
    if (cyc != 4 * int'(PLS + GAPC + 1)) begin
      n_fail++;
      $display("FAIL %s_init_cycles: init_done after %0d cycles, required %0d", name, cyc, 4 * (PLS + GAPC + 1));
    end
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_init_end: outstanding=%0d busy=%b req_ready=%b, required 0 0 1",
               name, exp_q.size(), busy, req_ready);
    end
    check_status(name, 4'hF, 4'hF);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_125mhz);
    n_cmp++;
    if (relay_a !== '0 || relay_b !== '0 || busy !== 1'b0 || init_done !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: a=%b b=%b busy=%b init_done=%b ready=%b, required all 0",
               relay_a, relay_b, busy, init_done, req_ready);
    end
    check_status("reset", 4'h0, 4'h0);
    for (int i = 0; i < int'(NCH); i++) push_exp(2'(i), 1'b1);
  endtask

  task automatic test_init;
    run_init("init");
  endtask

  task automatic test_drop;
    logic bad = 1'b0;
    send_req(2'd2, 1'b1);
    repeat (20) begin
      if (busy || (relay_a | relay_b) != '0) bad = 1'b1;
      @(negedge clk_125mhz);
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL drop_activity: busy or coil seen=1, required 0");
    end
    check_status("drop", 4'hF, 4'hF);
  endtask

  task automatic test_single_change;
    logic seen = 1'b0;
    logic bad  = 1'b0;
    int   k    = 0;
    push_exp(2'd1, 1'b0);
    send_req(2'd1, 1'b0);
    while (k < 60) begin
      if (busy) seen = 1'b1;
      if (seen && !busy) break;
      if (dir_known[1]) bad = 1'b1;
      @(negedge clk_125mhz);
      k++;
    end
    n_cmp++;
    if (k >= 60 || bad) begin
      n_fail++;
      $display("FAIL single_known: dir_known[1] high in flight=%b timeout=%b, required 0 0", bad, k >= 60);
    end
    wait_done("single", 20);
    check_status("single", 4'hD, 4'hF);
  endtask

  task automatic test_back_to_back;
    push_exp(2'd3, 1'b0);
    push_exp(2'd0, 1'b0);
    @(negedge clk_125mhz);
    req_valid = 1'b1; req_channel = 2'd3; req_dir = 1'b0;
    @(negedge clk_125mhz);
    req_channel = 2'd0; req_dir = 1'b0;
    @(negedge clk_125mhz);
    req_valid = 1'b0;
    wait_done("b2b", 100);
    check_status("b2b", 4'h4, 4'hF);
  endtask

  task automatic test_overwrite;
    int k = 0;
    push_exp(2'd0, 1'b1);
    send_req(2'd0, 1'b1);
    while (!relay_b[0] && k < 20) begin
      @(negedge clk_125mhz);
      k++;
    end
    n_cmp++;
    if (k >= 20) begin
      n_fail++;
      $display("FAIL overwrite_launch: relay_b[0] not seen in %0d cycles, required launch", k);
    end
    push_exp(2'd2, 1'b1);
    send_req(2'd2, 1'b0);
    n_cmp++;
    if (dir_known[2] !== 1'b0 || relay_b[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL overwrite_pending: dir_known[2]=%b relay_b[0]=%b, required 0 1", dir_known[2], relay_b[0]);
    end
    send_req(2'd2, 1'b1);
    wait_done("overwrite", 100);
    repeat (20) @(negedge clk_125mhz);
    n_cmp++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL overwrite_idle: busy=%b outstanding=%0d, required 0 0", busy, exp_q.size());
    end
    check_status("overwrite", 4'h5, 4'hF);
  endtask

  task automatic test_reset_mid_pulse;
    int k = 0;
    push_exp(2'd1, 1'b1);
    send_req(2'd1, 1'b1);
    while (!relay_b[1] && k < 20) begin
      @(negedge clk_125mhz);
      k++;
    end
    repeat (3) @(negedge clk_125mhz);
    n_cmp++;
    if (relay_b[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_active: relay_b[1]=%b before reset, required 1", relay_b[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (relay_a !== '0 || relay_b !== '0 || busy !== 1'b0 || init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: a=%b b=%b busy=%b init_done=%b, required all 0",
               relay_a, relay_b, busy, init_done);
    end
    check_status("rstmid", 4'h0, 4'h0);
    exp_q.delete();
    repeat (3) @(negedge clk_125mhz);
    for (int i = 0; i < int'(NCH); i++) push_exp(2'(i), 1'b1);
    run_init("reinit");
  endtask

  initial begin
    test_reset;
    test_init;
    test_drop;
    test_single_change;
    test_back_to_back;
    test_overwrite;
    test_reset_mid_pulse;
    repeat (5) @(negedge clk_125mhz);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
